// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with a valid/ready request and response interface.
// After reset, a scrub pass zeroes every word before any request is accepted.
`timescale 1ns/1ps

module data_mem_ctrl #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 128,
  localparam int NB     = DATA_W / 8,
  localparam int LOG_NB = $clog2(NB),
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int ADDR_W = IDX_W + LOG_NB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  scrub_cnt, scrub_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              legal;
  logic [3:0]        size_bytes;
  logic [IDX_W-1:0]  word_idx;
  int                lane_off;
  int                nbytes;
  logic [NB-1:0]     lane_en;
  logic [DATA_W-1:0] wdata_lanes;
  logic [DATA_W-1:0] rd_shift;
  logic              sign_bit;
  logic              fill;
  logic [DATA_W-1:0] load_data;

  // ---------------------------------------------------------------------------
  // Control FSM: SCRUB walks every word once, then RUN serves requests.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCRUB;
      scrub_cnt <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q   <= state_d;
      scrub_cnt <= scrub_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    scrub_d   = scrub_cnt;
    busy      = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      SCRUB: begin
        busy    = 1'b1;
        scrub_d = scrub_cnt + 1'b1;
        if (scrub_cnt == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        req_ready = !rsp_valid || rsp_ready;
      end
      default: state_d = SCRUB;
    endcase
  end

  assign accept = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Request decode: legality, lane selection and load formatting.
  // ---------------------------------------------------------------------------
  assign size_bytes = 4'd1 << req_size;
  assign legal      = (int'(size_bytes) <= NB) &&
                      ((req_addr & ADDR_W'(size_bytes - 4'd1)) == '0);
  assign word_idx   = req_addr[ADDR_W-1:LOG_NB];

  always_comb begin
    lane_off    = int'(req_addr & ADDR_W'(NB - 1));
    nbytes      = int'(size_bytes);
    wdata_lanes = req_wdata << (8 * lane_off);
    rd_shift    = mem[word_idx] >> (8 * lane_off);
    sign_bit    = 1'b0;
    lane_en     = '0;
    load_data   = '0;
    for (int i = 0; i < NB; i++) begin
      lane_en[i] = legal && (i >= lane_off) && (i < lane_off + nbytes);
      if (i == nbytes - 1) begin
        sign_bit = rd_shift[8*i+7];
      end
    end
    fill = !req_unsigned && sign_bit;
    // Lanes past the access size are the extension; a full-word access has none.
    for (int i = 0; i < NB; i++) begin
      load_data[8*i +: 8] = (i < nbytes) ? rd_shift[8*i +: 8] : {8{fill}};
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Reads are combinational, so a store lands before the next load.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; clearing it is the scrub's job, which keeps
  // it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (state_q == SCRUB) begin
      mem[scrub_cnt] <= '0;
    end else if (accept && req_we) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_en[i]) begin
          mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response register: one entry, held until the consumer takes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= !legal;
      rsp_rdata <= (legal && !req_we) ? load_data : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the driver queues expected responses,
// and a monitor compares them as the DUT hands them over.
`timescale 1ns/1ps

module tb_data_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   hs_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge when both are high.
  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d with nothing outstanding",
                 rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_rdata"}, rsp_rdata, mon_e.rdata);
        check({mon_e.name, "_err"}, 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [ADDR_W-1:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err);
    bit ok = 1'b0;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp_q.push_back('{exp_rdata, exp_err, name});
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: req_ready never rose within 300 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Called just after reset release: counts cycles until busy falls.
  task automatic wait_scrub(input string name);
    int   n = 0;
    logic bad_ready = 1'b0;
    check({name, "_busy_start"}, 32'(busy), 32'd1);
    while (busy && n < 400) begin
      if (req_ready) bad_ready = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_cycles"}, 32'(n), 32'd128);
    check({name, "_ready_low"}, 32'(bad_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({name, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({name, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    // A request held during the scrub must be ignored, not queued.
    req_valid = 1'b1;
    req_size  = 2'd2;
    req_addr  = 9'h1FC;
    @(negedge clk);
    reset = 1'b1;
    wait_scrub("scrub1");
    issue("ld_w_1fc", 1'b0, 2'd2, 1'b0, 9'h1FC, 32'h0, 32'h0000_0000, 1'b0);

    issue("st_w_004",   1'b1, 2'd2, 1'b0, 9'h004, 32'hDEAD_BEEF, 32'h0, 1'b0);
    issue("ld_bs_007",  1'b0, 2'd0, 1'b0, 9'h007, 32'h0, 32'hFFFF_FFDE, 1'b0);
    issue("ld_bu_007",  1'b0, 2'd0, 1'b1, 9'h007, 32'h0, 32'h0000_00DE, 1'b0);
    issue("ld_hs_006",  1'b0, 2'd1, 1'b0, 9'h006, 32'h0, 32'hFFFF_DEAD, 1'b0);
    issue("ld_hu_004",  1'b0, 2'd1, 1'b1, 9'h004, 32'h0, 32'h0000_BEEF, 1'b0);
    issue("st_b_005",   1'b1, 2'd0, 1'b0, 9'h005, 32'h1234_56AA, 32'h0, 1'b0);
    issue("ld_w_raw",   1'b0, 2'd2, 1'b0, 9'h004, 32'h0, 32'hDEAD_AAEF, 1'b0);

    issue("st_w_000",   1'b1, 2'd2, 1'b0, 9'h000, 32'h1122_3344, 32'h0, 1'b0);
    issue("ill_ld_w",   1'b0, 2'd2, 1'b0, 9'h006, 32'h0, 32'h0, 1'b1);
    issue("ill_st_h",   1'b1, 2'd1, 1'b0, 9'h003, 32'hFFFF_FFFF, 32'h0, 1'b1);
    issue("ill_ld_d",   1'b0, 2'd3, 1'b0, 9'h000, 32'h0, 32'h0, 1'b1);
    issue("ld_w_000",   1'b0, 2'd2, 1'b0, 9'h000, 32'h0, 32'h1122_3344, 1'b0);
    issue("st_h_002",   1'b1, 2'd1, 1'b0, 9'h002, 32'h5555_ABCD, 32'h0, 1'b0);
    issue("ld_w_000b",  1'b0, 2'd2, 1'b0, 9'h000, 32'h0, 32'hABCD_3344, 1'b0);
    issue("ld_hs_002",  1'b0, 2'd1, 1'b0, 9'h002, 32'h0, 32'hFFFF_ABCD, 1'b0);
    idle();
    drain("traffic");

    // Backpressure: the pending response must hold and block new requests.
    rsp_ready = 1'b0;
    issue("stall_ld", 1'b0, 2'd2, 1'b0, 9'h004, 32'h0, 32'hDEAD_AAEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rdata", rsp_rdata, 32'hDEAD_AAEF);
      check("stall_err", 32'(rsp_err), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    hs_cyc.delete();
    issue("b2b_0", 1'b0, 2'd2, 1'b0, 9'h004, 32'h0, 32'hDEAD_AAEF, 1'b0);
    issue("b2b_1", 1'b0, 2'd0, 1'b1, 9'h004, 32'h0, 32'h0000_00EF, 1'b0);
    issue("b2b_2", 1'b0, 2'd1, 1'b0, 9'h004, 32'h0, 32'hFFFF_AAEF, 1'b0);
    issue("b2b_3", 1'b0, 2'd1, 1'b1, 9'h006, 32'h0, 32'h0000_DEAD, 1'b0);
    idle();
    drain("b2b");
    check("b2b_count", 32'(hs_cyc.size()), 32'd5);
    for (int i = 1; i + 1 < hs_cyc.size(); i++) begin
      check("b2b_gap", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd1);
    end

    // Reset while a response is pending: it is dropped at once.
    rsp_ready = 1'b0;
    issue("dropped", 1'b0, 2'd2, 1'b0, 9'h000, 32'h0, 32'hABCD_3344, 1'b0);
    idle();
    @(negedge clk);
    check("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_rsp");
    exp_q.delete();
    rsp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    wait_scrub("scrub2");

    // Reset again partway through the scrub.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("mid_scrub_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_scrub");
    @(negedge clk);
    reset = 1'b1;
    wait_scrub("scrub3");

    issue("post_ld_004", 1'b0, 2'd2, 1'b0, 9'h004, 32'h0, 32'h0, 1'b0);
    issue("post_ld_000", 1'b0, 2'd2, 1'b0, 9'h000, 32'h0, 32'h0, 1'b0);
    idle();
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
